// File: rtl/wb_uart_tx_master_if.sv
// ---------------------------------------------------------------------------
// wb_uart_tx_master_if
// Wishbone (pipelined, single-beat) bus between the console transmitter
// (master) and a UART16550 register port (slave). Signal suffixes are given
// from the master's point of view.
//   wb_cyc_o   cycle in progress          wb_dat_i   read data ([7:0] used)
//   wb_stb_o   strobe                     wb_ack_i   transfer acknowledge
//   wb_we_o    1 = write                  wb_err_i   transfer error
//   wb_adr_o   byte address               wb_stall_i slave not accepting stb
//   wb_dat_o   write data {24'h0, byte}
//   wb_sel_o   byte select, 4'b0001 while stb is high
// ---------------------------------------------------------------------------
interface wb_uart_tx_master_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );
endinterface

// File: rtl/wb_uart_tx_master.sv
// ---------------------------------------------------------------------------
// wb_uart_tx_master
// Wishbone initiator that runs a UART16550 as a console transmitter without
// CPU help. After reset it programs divisor, 8N1 framing and the FIFOs, then
// drains a local byte FIFO into THR: it polls LSR.THRE and, once THRE is set,
// writes up to 16 bytes before polling again.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   tx_data_i/valid_i byte source; byte taken when valid & ready
//   tx_ready_o        local FIFO can accept (never in the error state)
//   init_done_o       UART register setup completed
//   busy_o            FIFO non-empty or bus cycle in progress
//   err_o             sticky bus error / ack timeout
//   wb                Wishbone master port (see wb_uart_tx_master_if)
// ---------------------------------------------------------------------------
module wb_uart_tx_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       init_done_o,
  output logic       busy_o,
  output logic       err_o,
  wb_uart_tx_master_if.master wb
);

  localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]    TMO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_POLL, S_SEND, S_ERR} state_t;

  // Register programming sequence: {register index, value}.
  // LCR=0x83 opens the divisor latch, DLL/DLM get the divisor, LCR=0x03
  // selects 8N1 and closes the latch, FCR=0x07 enables and clears the FIFOs,
  // IER=0x00 keeps interrupts off.
  function automatic logic [10:0] init_entry(input logic [2:0] step);
    case (step)
      3'd0:    init_entry = {3'd3, 8'h83};
      3'd1:    init_entry = {3'd0, DIVISOR[7:0]};
      3'd2:    init_entry = {3'd1, DIVISOR[15:8]};
      3'd3:    init_entry = {3'd3, 8'h03};
      3'd4:    init_entry = {3'd2, 8'h07};
      default: init_entry = {3'd1, 8'h00};
    endcase
  endfunction

  function automatic logic [31:0] reg_addr(input logic [2:0] idx);
    reg_addr = BASE_ADDR + {27'd0, idx, 2'b00};
  endfunction

  state_t      r_state;
  logic [2:0]  r_step;
  logic [4:0]  r_burst;
  logic [7:0]  r_tmo;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_init_done;
  logic        r_err;
  logic        r_rdy_en;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0] r_count;

  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_ack;
  logic        w_fail;
  logic [AW:0] w_count_next;
  logic        w_start;
  logic        w_we;
  logic [2:0]  w_reg;
  logic [7:0]  w_byte;
  logic        w_unused_dat;

  assign w_full       = (r_count == DEPTH_C);
  assign w_push       = tx_valid_i & tx_ready_o;
  // An ack accompanied by err counts as an error, so the byte stays queued.
  assign w_ack        = r_cyc & wb.wb_ack_i & ~wb.wb_err_i;
  assign w_fail       = r_cyc & (wb.wb_err_i | (~wb.wb_ack_i & (r_tmo == TMO_LAST)));
  assign w_pop        = w_ack & (r_state == S_SEND);
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_unused_dat = ^{wb.wb_dat_i[31:6], wb.wb_dat_i[4:0]};

  // Access request for the current state. A new access is only launched
  // while cyc is low; since cyc drops on the edge that sees ack, this leaves
  // exactly one idle bus cycle between accesses.
  always_comb begin
    w_start = 1'b0;
    w_we    = 1'b0;
    w_reg   = 3'd0;
    w_byte  = 8'h00;
    case (r_state)
      S_INIT: begin
        w_start        = ~r_cyc;
        w_we           = 1'b1;
        {w_reg, w_byte} = init_entry(r_step);
      end
      S_POLL: begin
        w_start = ~r_cyc;
        w_reg   = 3'd5;
      end
      S_SEND: begin
        w_start = ~r_cyc;
        w_we    = 1'b1;
        w_byte  = r_mem[r_rptr];
      end
      default: ;
    endcase
  end

  // Control FSM and bus cycle engine
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_INIT;
      r_step      <= 3'd0;
      r_burst     <= 5'd0;
      r_tmo       <= 8'd0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 32'h0;
      r_dat       <= 32'h0;
      r_sel       <= 4'h0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;

      if (w_start) begin
        r_cyc <= 1'b1;
        r_stb <= 1'b1;
        r_we  <= w_we;
        r_adr <= reg_addr(w_reg);
        r_dat <= {24'h0, w_byte};
        r_sel <= 4'b0001;
        r_tmo <= 8'd0;
      end else if (r_cyc) begin
        if (r_stb && !wb.wb_stall_i) begin
          r_stb <= 1'b0;
          r_sel <= 4'h0;
        end
        if (w_ack || w_fail) begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          r_sel <= 4'h0;
        end else begin
          r_tmo <= r_tmo + 8'd1;
        end
      end

      if (w_fail) begin
        r_err    <= 1'b1;
        r_rdy_en <= 1'b0;
        r_state  <= S_ERR;
      end else begin
        case (r_state)
          S_INIT: begin
            if (w_ack) begin
              if (r_step == 3'd5) begin
                r_init_done <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_step <= r_step + 3'd1;
              end
            end
          end
          S_IDLE: begin
            if (r_count != '0) r_state <= S_POLL;
          end
          S_POLL: begin
            if (w_ack) begin
              if (wb.wb_dat_i[5]) begin
                r_burst <= 5'd16;
                r_state <= S_SEND;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          S_SEND: begin
            if (w_ack) begin
              r_burst <= r_burst - 5'd1;
              if (r_burst == 5'd1 || w_count_next == '0) r_state <= S_IDLE;
            end
          end
          default: begin
            r_rdy_en <= 1'b0;
          end
        endcase
      end
    end
  end

  // Local byte FIFO; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= tx_data_i;
  end

  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_stb;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_adr_o = r_adr;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_sel_o = r_sel;

  assign tx_ready_o  = r_rdy_en & ~w_full;
  assign init_done_o = r_init_done;
  assign busy_o      = (r_count != '0) | r_cyc;
  assign err_o       = r_err;

endmodule

// File: tb/tb_wb_uart_tx_master.sv
module tb_wb_uart_tx_master;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, init_done, busy, err;

  wb_uart_tx_master_if wbb();

  wb_uart_tx_master #(
    .BASE_ADDR  (32'h0000_0000),
    .DIVISOR    (16'd27),
    .FIFO_DEPTH (16),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .init_done_o(init_done),
    .busy_o     (busy),
    .err_o      (err),
    .wb         (wbb)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t       log_q[$];
  txn_t       exp_q[$];
  logic [7:0] byte_q[$];
  logic [7:0] lsr_q[$];

  int total = 0;
  int bad   = 0;

  // slave configuration / observation
  int          dly_min = 0, dly_max = 0;
  bit          never_ack = 0;
  int          stall_left = 0, stall_seen = 0, stall_bad = 0, proto_bad = 0;
  logic [31:0] stall_adr, stall_dat;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [7:0]  pend_resp;
  int          sl_d;
  logic [7:0]  sl_resp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural UART register slave, evaluated mid-cycle
  initial begin
    wbb.wb_ack_i   = 1'b0;
    wbb.wb_err_i   = 1'b0;
    wbb.wb_stall_i = 1'b0;
    wbb.wb_dat_i   = 32'h0;
    forever begin
      @(negedge clk);
      wbb.wb_ack_i   = 1'b0;
      wbb.wb_stall_i = 1'b0;
      wbb.wb_dat_i   = 32'h0;
      if (rst) begin
        pend = 0;
      end else if (wbb.wb_cyc_o) begin
        if (pend) begin
          if (wbb.wb_stb_o) proto_bad++;
          if (pend_cnt == 0) begin
            wbb.wb_ack_i = 1'b1;
            wbb.wb_dat_i = {24'h0, pend_resp};
            pend = 0;
          end else begin
            pend_cnt--;
          end
        end else if (wbb.wb_stb_o && !never_ack) begin
          if (stall_left > 0 && wbb.wb_we_o && wbb.wb_adr_o == 32'h0) begin
            wbb.wb_stall_i = 1'b1;
            if (stall_seen == 0) begin
              stall_adr = wbb.wb_adr_o;
              stall_dat = wbb.wb_dat_o;
            end else if (wbb.wb_adr_o !== stall_adr || wbb.wb_dat_o !== stall_dat) begin
              stall_bad++;
            end
            stall_seen++;
            stall_left--;
          end else begin
            if (wbb.wb_sel_o !== 4'b0001) proto_bad++;
            if (stall_seen > 0 && wbb.wb_we_o &&
                (wbb.wb_adr_o !== stall_adr || wbb.wb_dat_o !== stall_dat)) stall_bad++;
            sl_resp = 8'h60;
            if (!wbb.wb_we_o && lsr_q.size() > 0) sl_resp = lsr_q.pop_front();
            log_q.push_back('{wbb.wb_we_o, wbb.wb_adr_o, wbb.wb_we_o ? wbb.wb_dat_o : 32'h0});
            sl_d = $urandom_range(dly_max, dly_min);
            if (sl_d == 0) begin
              wbb.wb_ack_i = 1'b1;
              wbb.wb_dat_i = {24'h0, sl_resp};
            end else begin
              pend      = 1;
              pend_cnt  = sl_d - 1;
              pend_resp = sl_resp;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic add_exp(input bit we, input logic [31:0] adr, input logic [31:0] dat);
    exp_q.push_back('{we, adr, dat});
  endtask

  // Console traffic as the UART sees it: not-ready polls, then for every
  // group of up to 16 queued bytes one THRE poll followed by the THR writes.
  task automatic build_send_exp(input int notready, input int nbytes);
    int rem = nbytes;
    int chunk;
    for (int i = 0; i < notready; i++) add_exp(1'b0, 32'h14, 32'h0);
    while (rem > 0) begin
      add_exp(1'b0, 32'h14, 32'h0);
      chunk = (rem > 16) ? 16 : rem;
      for (int i = 0; i < chunk; i++) add_exp(1'b1, 32'h00, {24'h0, byte_q.pop_front()});
      rem -= chunk;
    end
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) begin
        check($sformatf("%s_we%0d", tag, i), log_q[i].we, exp_q[i].we);
        check($sformatf("%s_adr%0d", tag, i), log_q[i].adr, exp_q[i].adr);
        check($sformatf("%s_dat%0d", tag, i), log_q[i].dat, exp_q[i].dat);
      end
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_cyc"}, wbb.wb_cyc_o, 0);
    check({tag, "_rst_stb"}, wbb.wb_stb_o, 0);
    check({tag, "_rst_we"}, wbb.wb_we_o, 0);
    check({tag, "_rst_adr"}, wbb.wb_adr_o, 0);
    check({tag, "_rst_dat"}, wbb.wb_dat_o, 0);
    check({tag, "_rst_sel"}, wbb.wb_sel_o, 0);
    check({tag, "_rst_ready"}, tx_ready, 0);
    check({tag, "_rst_init"}, init_done, 0);
    check({tag, "_rst_busy"}, busy, 0);
    check({tag, "_rst_err"}, err, 0);
    log_q.delete();
    lsr_q.delete();
    byte_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_init_done"}, init_done, 1);
    add_exp(1'b1, 32'h0C, 32'h83);
    add_exp(1'b1, 32'h00, 32'h1B);
    add_exp(1'b1, 32'h04, 32'h00);
    add_exp(1'b1, 32'h0C, 32'h03);
    add_exp(1'b1, 32'h08, 32'h07);
    add_exp(1'b1, 32'h04, 32'h00);
    compare_log({tag, "_init"});
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("push_ready_timeout", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    byte_q.push_back(b);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int cyc_cnt;
    logic [7:0] b;

    // 1: reset and register programming
    do_reset("t1");
    wait_init("t1");

    // 2: single byte
    push(8'h41);
    build_send_exp(0, 1);
    wait_drain("t2");
    compare_log("t2");
    check("t2_busy", busy, 0);
    check("t2_ready", tx_ready, 1);

    // 3: 20 bytes -> 16-byte burst, then re-poll, then 4
    for (int i = 0; i < 20; i++) push(8'($urandom));
    build_send_exp(0, 20);
    wait_drain("t3");
    compare_log("t3");

    // 4: THRE clear three times before set
    lsr_q.push_back(8'h00);
    lsr_q.push_back(8'h00);
    lsr_q.push_back(8'h00);
    lsr_q.push_back(8'h20);
    push(8'($urandom));
    build_send_exp(3, 1);
    wait_drain("t4");
    compare_log("t4");

    // 5: five stall cycles on a THR write
    stall_left = 5;
    stall_seen = 0;
    stall_bad  = 0;
    push(8'($urandom));
    build_send_exp(0, 1);
    wait_drain("t5");
    compare_log("t5");
    check("t5_stall_cycles", stall_seen, 5);
    check("t5_stall_stable", stall_bad, 0);
    stall_seen = 0;

    // random lengths and ack latencies
    dly_min = 0;
    dly_max = 2;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(40, 17);
      for (int i = 0; i < n; i++) push(8'($urandom));
      build_send_exp(0, n);
      wait_drain($sformatf("rnd%0d", r));
      compare_log($sformatf("rnd%0d", r));
    end

    // FIFO fills during a slow init, then drains in order
    dly_min = 5;
    dly_max = 5;
    do_reset("full");
    for (int i = 0; i < 16; i++) push(8'($urandom));
    check("full_ready", tx_ready, 0);
    check("full_busy", busy, 1);
    check("full_init_pending", init_done, 0);
    wait_init("full");
    for (int i = 0; i < 8; i++) push(8'($urandom));
    dly_min = 0;
    dly_max = 2;
    build_send_exp(0, 24);
    wait_drain("full");
    compare_log("full");

    // 6: ack timeout -> sticky error
    dly_min = 0;
    dly_max = 0;
    never_ack = 1;
    b = 8'($urandom);
    push(b);
    n = 0;
    cyc_cnt = 0;
    do begin
      @(negedge clk);
      if (wbb.wb_cyc_o) cyc_cnt++;
      n++;
    end while (!err && n < 200);
    check("t6_err", err, 1);
    check("t6_cyc_cycles", cyc_cnt, TMO);
    check("t6_cyc", wbb.wb_cyc_o, 0);
    check("t6_stb", wbb.wb_stb_o, 0);
    check("t6_ready", tx_ready, 0);
    check("t6_busy", busy, 1);
    repeat (5) @(negedge clk);
    check("t6_err_sticky", err, 1);
    check("t6_cyc_held", wbb.wb_cyc_o, 0);
    check("t6_ready_held", tx_ready, 0);
    never_ack = 0;
    log_q.delete();

    do_reset("t6");
    n = 0;
    while (!wbb.wb_cyc_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_restart_cyc", wbb.wb_cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_midrst_cyc", wbb.wb_cyc_o, 0);
    check("t6_midrst_stb", wbb.wb_stb_o, 0);
    do_reset("t6b");
    wait_init("t6b");
    push(8'h5A);
    build_send_exp(0, 1);
    wait_drain("t6b");
    compare_log("t6b");
    check("protocol", proto_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
